// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button conditioning path.
package button_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // Counter width wide enough for the larger of the debounce and hold spans.
   function automatic int cnt_width(input int deb, input int hold);
      int span;
      if (deb > hold) begin
         span = deb;
      end else begin
         span = hold;
      end
      return $clog2(span + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs, synchronous reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_r;
   logic s2_r;

   // Metastability filter: first flop may go metastable, second one settles.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s1_r <= d;
         s2_r <= s1_r;
      end
   end

   assign q = s2_r;

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw push-button into level, press/release pulses and a one-shot hold event.
// The release pulse port is named release_pulse because "release" is a reserved word.
module button_debounce
   import button_pkg::*;
#(
   parameter int DEB        = 240000,
   parameter int HOLD       = 12000000,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic button_in,
   output logic level,
   output logic press,
   output logic release_pulse,
   output logic hold
);

   localparam int W = cnt_width(DEB, HOLD);
   localparam logic [W-1:0] ZERO      = W'(0);
   localparam logic [W-1:0] ONE       = W'(1);
   localparam logic [W-1:0] DEB_LAST  = W'(DEB - 1);
   localparam logic [W-1:0] HOLD_LAST = W'(HOLD - 1);
   localparam logic [W-1:0] HOLD_MAX  = W'(HOLD);

   logic       b_s;
   logic       s2_s;
   btn_state_t state_r, state_s;
   logic [W-1:0] cnt_r, cnt_s;
   logic [W-1:0] hcnt_r, hcnt_s;
   logic       hdone_r, hdone_s;
   logic       level_r, level_s;
   logic       press_r, press_s;
   logic       release_r, release_s;
   logic       hold_r, hold_s;
   logic       holding_s;
   logic       hold_due_s;

   assign b_s = button_in ^ ACTIVE_LOW;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (b_s),
      .q   (s2_s)
   );

   // Next-state, counters and output pulses.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      hcnt_s    = hcnt_r;
      hdone_s   = hdone_r;
      level_s   = level_r;
      press_s   = 1'b0;
      release_s = 1'b0;
      hold_s    = 1'b0;

      holding_s  = (state_r == PRESSED) || (state_r == RELEASE_WAIT);
      hold_due_s = holding_s && (hcnt_r == HOLD_LAST) && !hdone_r;

      // Release bounces keep counting so hold timing is measured from the press.
      if (holding_s && (hcnt_r < HOLD_MAX)) begin
         hcnt_s = hcnt_r + ONE;
      end else begin
         hcnt_s = hcnt_r;
      end

      case (state_r)
         IDLE: begin
            if (s2_s) begin
               state_s = PRESS_WAIT;
               cnt_s   = ONE;
            end else begin
               state_s = IDLE;
            end
         end
         PRESS_WAIT: begin
            if (!s2_s) begin
               state_s = IDLE;
               cnt_s   = ZERO;
            end else if (cnt_r == DEB_LAST) begin
               state_s = PRESSED;
               press_s = 1'b1;
               level_s = 1'b1;
               hcnt_s  = ZERO;
               hdone_s = 1'b0;
            end else begin
               cnt_s = cnt_r + ONE;
            end
         end
         PRESSED: begin
            if (!s2_s) begin
               state_s = RELEASE_WAIT;
               cnt_s   = ONE;
            end else begin
               state_s = PRESSED;
            end
         end
         RELEASE_WAIT: begin
            if (s2_s) begin
               state_s = PRESSED;
               cnt_s   = ZERO;
            end else if (cnt_r == DEB_LAST) begin
               state_s   = IDLE;
               release_s = 1'b1;
               level_s   = 1'b0;
            end else begin
               cnt_s = cnt_r + ONE;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = ZERO;
            level_s = 1'b0;
         end
      endcase

      // An accepted release on the hold edge consumes the hold for this press.
      if (hold_due_s) begin
         hdone_s = 1'b1;
         hold_s  = !release_s;
      end else begin
         hold_s = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= ZERO;
         hcnt_r    <= ZERO;
         hdone_r   <= 1'b0;
         level_r   <= 1'b0;
         press_r   <= 1'b0;
         release_r <= 1'b0;
         hold_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         hcnt_r    <= hcnt_s;
         hdone_r   <= hdone_s;
         level_r   <= level_s;
         press_r   <= press_s;
         release_r <= release_s;
         hold_r    <= hold_s;
      end
   end

   assign level         = level_r;
   assign press         = press_r;
   assign release_pulse = release_r;
   assign hold          = hold_r;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench: DEB=4, HOLD=10; an active-high and an active-low instance see
// complementary pins and must both produce the same hand-computed trace.
module tb_button_debounce;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn = 1'b0;
   logic btn_n;
   logic level0, press0, rel0, hold0;
   logic level1, press1, rel1, hold1;
   int   checks = 0;
   int   errors = 0;

   // Expected {level, press, release, hold}
   localparam logic [3:0] Z = 4'b0000;
   localparam logic [3:0] P = 4'b1100;
   localparam logic [3:0] L = 4'b1000;
   localparam logic [3:0] R = 4'b0010;
   localparam logic [3:0] H = 4'b1001;

   assign btn_n = ~btn;

   always #5 clk = ~clk;

   button_debounce #(.DEB(4), .HOLD(10), .ACTIVE_LOW(1'b0)) dut_hi (
      .clk(clk), .rst(rst), .button_in(btn),
      .level(level0), .press(press0), .release_pulse(rel0), .hold(hold0)
   );

   button_debounce #(.DEB(4), .HOLD(10), .ACTIVE_LOW(1'b1)) dut_lo (
      .clk(clk), .rst(rst), .button_in(btn_n),
      .level(level1), .press(press1), .release_pulse(rel1), .hold(hold1)
   );

   task automatic cyc(input string tag, input logic [3:0] exp);
      @(posedge clk);
      #1;
      checks++;
      assert ({level0, press0, rel0, hold0} === exp) else begin
         errors++;
         $error("FAIL %s active_high obs=%b exp=%b", tag, {level0, press0, rel0, hold0}, exp);
      end
      checks++;
      assert ({level1, press1, rel1, hold1} === exp) else begin
         errors++;
         $error("FAIL %s active_low obs=%b exp=%b", tag, {level1, press1, rel1, hold1}, exp);
      end
   endtask

   initial begin
      // Reset with the button held, then a fresh press after deassert.
      rst = 1'b1;
      btn = 1'b1;
      repeat (3) cyc("reset", Z);
      rst = 1'b0;
      repeat (5) cyc("rst_deb", Z);
      cyc("rst_press", P);
      repeat (3) cyc("rst_level", L);
      btn = 1'b0;
      repeat (5) cyc("rst_rel_wait", L);
      cyc("rst_release", R);
      repeat (4) cyc("rst_idle", Z);

      // Clean long press: hold at E0+15 exactly once.
      btn = 1'b1;
      repeat (5) cyc("long_deb", Z);
      cyc("long_press", P);
      repeat (9) cyc("long_level", L);
      cyc("long_hold", H);
      repeat (24) cyc("long_after_hold", L);
      btn = 1'b0;
      repeat (5) cyc("long_rel_wait", L);
      cyc("long_release", R);
      repeat (3) cyc("long_idle", Z);

      // Press bounce: 1, 2 and 3 cycle blips are all rejected.
      for (int w = 1; w <= 3; w++) begin
         btn = 1'b1;
         repeat (w) cyc("bounce_hi", Z);
         btn = 1'b0;
         repeat (4) cyc("bounce_lo", Z);
      end

      // Release bounce: 2-cycle low does not release or restart the hold timer.
      btn = 1'b1;
      repeat (5) cyc("rb_deb", Z);
      cyc("rb_press", P);
      repeat (3) cyc("rb_level", L);
      btn = 1'b0;
      repeat (2) cyc("rb_bounce_lo", L);
      btn = 1'b1;
      repeat (4) cyc("rb_bounce_hi", L);
      cyc("rb_hold", H);
      repeat (4) cyc("rb_after_hold", L);
      btn = 1'b0;
      repeat (5) cyc("rb_rel_wait", L);
      cyc("rb_release", R);
      repeat (2) cyc("rb_idle", Z);

      // Short press: released before the hold point.
      btn = 1'b1;
      repeat (5) cyc("short_deb", Z);
      cyc("short_press", P);
      repeat (2) cyc("short_level", L);
      btn = 1'b0;
      repeat (5) cyc("short_rel_wait", L);
      cyc("short_release", R);
      repeat (4) cyc("short_no_hold", Z);

      // Collision: release accepted on the hold edge wins.
      btn = 1'b1;
      repeat (5) cyc("coll_deb", Z);
      cyc("coll_press", P);
      repeat (4) cyc("coll_level", L);
      btn = 1'b0;
      repeat (5) cyc("coll_rel_wait", L);
      cyc("coll_release", R);
      repeat (4) cyc("coll_no_hold", Z);

      // Reset in PRESS_WAIT, re-debounce, then reset in PRESSED.
      btn = 1'b1;
      repeat (3) cyc("pw_deb", Z);
      rst = 1'b1;
      repeat (2) cyc("pw_reset", Z);
      rst = 1'b0;
      repeat (5) cyc("pw_redeb", Z);
      cyc("pw_press", P);
      repeat (2) cyc("pw_level", L);
      rst = 1'b1;
      repeat (2) cyc("pressed_reset", Z);
      rst = 1'b0;
      btn = 1'b0;
      repeat (6) cyc("post_reset_idle", Z);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
